// File: rtl/int2flt_seq.sv
// Multi-cycle integer to floating-point converter with start/done handshake.
// Normalises by one bit per cycle, then rounds (nearest-even or truncate) and saturates.

module int2flt_seq #(
   parameter int unsigned INT_W = 16,
   parameter int unsigned EXP_W = 5,
   parameter int unsigned MAN_W = 10,
   parameter int unsigned BIAS  = 15
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Start,
   input  logic                   Sgn,
   input  logic                   Rnd,
   input  logic [INT_W-1:0]       Int_in,
   output logic [EXP_W+MAN_W:0]   Flt,
   output logic                   Done,
   output logic                   Busy,
   output logic                   Ovf
);

   localparam int unsigned XW = INT_W + MAN_W;
   localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(BIAS + INT_W - 1);
   localparam logic [EXP_W-1:0] EXP_SAT = EXP_W'((2 ** EXP_W) - 2);

   if (BIAS + INT_W - 1 > (2 ** EXP_W) - 2) begin : g_bias_check
      $error("int2flt_seq: BIAS+INT_W-1 exceeds the largest finite exponent");
   end
   if (INT_W < 2) begin : g_width_check
      $error("int2flt_seq: INT_W must be at least 2");
   end

   typedef enum logic [1:0] {
      StIdle,
      StNorm,
      StRound,
      StDone
   } state_e;

   state_e                 state_q, state_d;
   logic                   sign_q, sign_d;
   logic                   rnd_q, rnd_d;
   logic [INT_W-1:0]       mag_q, mag_d;
   logic [EXP_W-1:0]       exp_q, exp_d;
   logic [EXP_W+MAN_W:0]   flt_q, flt_d;
   logic                   ovf_q, ovf_d;

   // Fraction bits below the leading one, padded so guard and sticky always exist.
   logic [XW-1:0]          ext;
   logic [MAN_W-1:0]       man;
   logic                   guard;
   logic                   sticky;
   logic                   round_up;
   logic [MAN_W:0]         man_sum;
   logic [EXP_W-1:0]       exp_rnd;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= StIdle;
         sign_q  <= 1'b0;
         rnd_q   <= 1'b0;
         mag_q   <= '0;
         exp_q   <= '0;
         flt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         rnd_q   <= rnd_d;
         mag_q   <= mag_d;
         exp_q   <= exp_d;
         flt_q   <= flt_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      rnd_d   = rnd_q;
      mag_d   = mag_q;
      exp_d   = exp_q;
      flt_d   = flt_q;
      ovf_d   = ovf_q;

      ext      = {mag_q[INT_W-2:0], {(MAN_W+1){1'b0}}};
      man      = ext[XW-1 -: MAN_W];
      guard    = ext[XW-1-MAN_W];
      sticky   = |ext[XW-2-MAN_W:0];
      round_up = ~rnd_q & guard & (man[0] | sticky);
      man_sum  = {1'b0, man} + {{MAN_W{1'b0}}, round_up};
      exp_rnd  = exp_q + {{(EXP_W-1){1'b0}}, man_sum[MAN_W]};

      case (state_q)
         StIdle: begin
            if (Start) begin
               sign_d = Sgn & Int_in[INT_W-1];
               // Negating the most negative value wraps to the correct unsigned magnitude.
               mag_d  = sign_d ? (~Int_in + INT_W'(1)) : Int_in;
               exp_d  = EXP_TOP;
               rnd_d  = Rnd;
               if (Int_in == '0) begin
                  flt_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = StDone;
               end else begin
                  state_d = StNorm;
               end
            end
         end
         StNorm: begin
            if (!mag_q[INT_W-1]) begin
               mag_d = mag_q << 1;
               exp_d = exp_q - EXP_W'(1);
            end else begin
               state_d = StRound;
            end
         end
         StRound: begin
            if (exp_rnd == '1) begin
               flt_d = {sign_q, EXP_SAT, {MAN_W{1'b1}}};
               ovf_d = 1'b1;
            end else begin
               flt_d = {sign_q, exp_rnd, man_sum[MAN_W-1:0]};
               ovf_d = 1'b0;
            end
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign Flt  = flt_q;
   assign Ovf  = ovf_q;
   assign Done = (state_q == StDone);
   assign Busy = (state_q != StIdle);

endmodule

// File: tb/tb_int2flt_seq.sv
// Bench for int2flt_seq: directed vectors from the datasheet plus randomized operands
// checked against an arithmetic reference model.

module tb_int2flt_seq;

   localparam int INT_W = 16;
   localparam int EXP_W = 5;
   localparam int MAN_W = 10;
   localparam int BIAS  = 15;
   localparam int FW    = 1 + EXP_W + MAN_W;
   localparam int LAT_LIMIT = INT_W + 10;

   logic              Clk;
   logic              Reset;
   logic              Start;
   logic              Sgn;
   logic              Rnd;
   logic [INT_W-1:0]  Int_in;
   logic [FW-1:0]     Flt;
   logic              Done;
   logic              Busy;
   logic              Ovf;

   int n_total;
   int n_bad;

   int2flt_seq #(
      .INT_W (INT_W),
      .EXP_W (EXP_W),
      .MAN_W (MAN_W),
      .BIAS  (BIAS)
   ) dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .Start  (Start),
      .Sgn    (Sgn),
      .Rnd    (Rnd),
      .Int_in (Int_in),
      .Flt    (Flt),
      .Done   (Done),
      .Busy   (Busy),
      .Ovf    (Ovf)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Value-level reference: exact fraction, then round on the remainder.
   function automatic void model(input logic [INT_W-1:0] v, input logic sgn, input logic rnd,
                                 output logic [FW-1:0] flt, output logic ovf, output int lat);
      longint mag, num, q, rem, one_e;
      int     e, be;
      logic   s;
      s   = sgn & v[INT_W-1];
      mag = s ? ((longint'(1) << INT_W) - longint'(v)) : longint'(v);
      ovf = 1'b0;
      if (mag == 0) begin
         flt = '0;
         lat = 1;
         return;
      end
      e = 0;
      while ((mag >> (e + 1)) != 0) e++;
      lat   = INT_W + 2 - e;
      one_e = longint'(1) << e;
      num   = (mag - one_e) << MAN_W;
      q     = num >> e;
      rem   = num - (q << e);
      if (!rnd && ((2 * rem > one_e) || (2 * rem == one_e && (q % 2) == 1))) q++;
      if (q == (longint'(1) << MAN_W)) begin
         q = 0;
         e++;
      end
      be = e + BIAS;
      if (be >= (1 << EXP_W) - 1) begin
         be  = (1 << EXP_W) - 2;
         q   = (longint'(1) << MAN_W) - 1;
         ovf = 1'b1;
      end
      flt = {s, be[EXP_W-1:0], q[MAN_W-1:0]};
   endfunction

   task automatic run_conv(input string tag, input logic [INT_W-1:0] val, input logic sgn,
                           input logic rnd, input logic hold, input logic [FW-1:0] exp_flt,
                           input logic exp_ovf, input int exp_lat);
      int   edges;
      int   extra;
      logic seen;
      @(negedge Clk);
      Int_in = val;
      Sgn    = sgn;
      Rnd    = rnd;
      Start  = 1'b1;
      edges  = 0;
      seen   = 1'b0;
      while (!seen && edges < LAT_LIMIT) begin
         @(posedge Clk);
         edges++;
         @(negedge Clk);
         if (edges == 1) check_val({tag, ".busy"}, 32'(Busy), 32'd1);
         if (Done) seen = 1'b1;
         if (!hold || seen) Start = 1'b0;
         // Operand churn while busy must not disturb the latched conversion.
         if (!seen) begin
            Int_in = INT_W'($urandom);
            Sgn    = 1'($urandom);
            Rnd    = 1'($urandom);
         end
      end
      check_val({tag, ".lat"}, 32'(edges), 32'(exp_lat));
      check_val({tag, ".flt"}, 32'(Flt), 32'(exp_flt));
      check_val({tag, ".ovf"}, 32'(Ovf), 32'(exp_ovf));
      extra = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge Clk);
         @(negedge Clk);
         if (Done) extra++;
      end
      check_val({tag, ".extra_done"}, 32'(extra), 32'd0);
      check_val({tag, ".idle"}, 32'(Busy), 32'd0);
   endtask

   typedef struct {
      logic [15:0] val;
      logic        sgn;
      logic        rnd;
      logic        hold;
      logic [15:0] flt;
      logic        ovf;
      int          lat;
   } vec_t;

   vec_t dirs [12] = '{
      '{16'h0001, 1'b1, 1'b0, 1'b0, 16'h3C00, 1'b0, 18},
      '{16'hFFFF, 1'b1, 1'b0, 1'b0, 16'hBC00, 1'b0, 18},
      '{16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1},
      '{16'h8000, 1'b1, 1'b0, 1'b0, 16'hF800, 1'b0, 3},
      '{16'h1002, 1'b1, 1'b0, 1'b0, 16'h6C00, 1'b0, 6},
      '{16'h1006, 1'b1, 1'b0, 1'b0, 16'h6C02, 1'b0, 6},
      '{16'h7FF8, 1'b1, 1'b0, 1'b0, 16'h7800, 1'b0, 4},
      '{16'h1002, 1'b1, 1'b1, 1'b0, 16'h6C00, 1'b0, 6},
      '{16'h1006, 1'b1, 1'b1, 1'b1, 16'h6C01, 1'b0, 6},
      '{16'h7FF8, 1'b1, 1'b1, 1'b0, 16'h77FF, 1'b0, 4},
      '{16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h7BFF, 1'b0, 3},
      '{16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h7BFF, 1'b1, 3}
   };

   initial begin
      logic [INT_W-1:0] val;
      logic             sgn;
      logic             rnd;
      logic [FW-1:0]    m_flt;
      logic             m_ovf;
      int               m_lat;
      int               stray;

      n_total = 0;
      n_bad   = 0;
      Reset   = 1'b1;
      Start   = 1'b0;
      Sgn     = 1'b0;
      Rnd     = 1'b0;
      Int_in  = '0;

      #2 Reset = 1'b0;
      #1;
      check_val("rst.flt", 32'(Flt), 32'd0);
      check_val("rst.done", 32'(Done), 32'd0);
      check_val("rst.busy", 32'(Busy), 32'd0);
      check_val("rst.ovf", 32'(Ovf), 32'd0);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_conv($sformatf("dir%0d", i), dirs[i].val, dirs[i].sgn, dirs[i].rnd, dirs[i].hold,
                  dirs[i].flt, dirs[i].ovf, dirs[i].lat);
      end

      // Abort a long conversion mid-normalisation; Flt and Ovf are nonzero beforehand.
      @(negedge Clk);
      Int_in = 16'h0001;
      Sgn    = 1'b1;
      Rnd    = 1'b0;
      Start  = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      check_val("abort.flt", 32'(Flt), 32'd0);
      check_val("abort.done", 32'(Done), 32'd0);
      check_val("abort.busy", 32'(Busy), 32'd0);
      check_val("abort.ovf", 32'(Ovf), 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      stray = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge Clk);
         @(negedge Clk);
         if (Done || Busy) stray++;
      end
      check_val("abort.stray", 32'(stray), 32'd0);
      run_conv("post_abort", 16'h0030, 1'b1, 1'b0, 1'b0, 16'h5200, 1'b0, 13);

      for (int i = 0; i < 300; i++) begin
         val = INT_W'($urandom);
         if (i % 2 == 1) val = val >> $urandom_range(0, INT_W - 1);
         if (i % 37 == 0) val = '0;
         if (i % 41 == 0) val = {1'b1, {(INT_W-1){1'b0}}};
         sgn = 1'($urandom);
         rnd = 1'($urandom);
         model(val, sgn, rnd, m_flt, m_ovf, m_lat);
         run_conv($sformatf("rnd%0d_%h_s%0d_r%0d", i, val, sgn, rnd), val, sgn, rnd,
                  1'($urandom_range(0, 3) == 0), m_flt, m_ovf, m_lat);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
